// File: rtl/dvp_pattern_gen_if.sv
// DVP camera bus: frame sync, line valid and pixel byte, driven by the sensor side.
interface dvp_pattern_gen_if #(
    parameter int DATA_W = 8
);
    logic              CCD_VSYNC;
    logic              CCD_HSYNC;
    logic [DATA_W-1:0] CCD_DATA;

    modport master (output CCD_VSYNC, output CCD_HSYNC, output CCD_DATA);
    modport slave  (input  CCD_VSYNC, input  CCD_HSYNC, input  CCD_DATA);
endinterface

// File: rtl/dvp_pattern_gen.sv
// Synthetic DVP sensor: emits VSYNC/HSYNC/DATA frames with a selectable test pattern,
// standing in for the OV5640 in loopback and capture-pipeline simulation.
module dvp_pattern_gen #(
    parameter int DATA_W        = 8,
    parameter int MAX_H         = 2048,
    parameter int MAX_V         = 2048,
    parameter int VS_CYCLES     = 10000,
    parameter int H_BLANK       = 100,
    parameter int BYTES_PER_PIX = 1
) (
    input  logic              CCD_PCLK,
    input  logic              CCD_RSTN,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [11:0]       h_active,
    input  logic [11:0]       v_active,
    dvp_pattern_gen_if.master dvp,
    output logic              frame_start,
    output logic [15:0]       frame_cnt
);

    localparam int CNT_MAX = (VS_CYCLES > H_BLANK) ? VS_CYCLES : H_BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(VS_CYCLES - 1);
    localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
    localparam logic [11:0]      MAX_H_L = 12'(MAX_H);
    localparam logic [11:0]      MAX_V_L = 12'(MAX_V);
    localparam logic             PH_LAST = (BYTES_PER_PIX == 2);

    typedef enum logic [1:0] {IDLE, VS, HBL, ACT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       x_q, x_d, y_q, y_d;
    logic              ph_q, ph_d;
    logic [DATA_W-1:0] ctr_q, ctr_d;
    logic [2:0]        bar_q, bar_d;
    logic [11:0]       bar_pix_q, bar_pix_d;
    logic [1:0]        mode_q, mode_d;
    logic [11:0]       h_eff_q, h_eff_d, v_eff_q, v_eff_d, bw_q, bw_d;
    logic              vsync_q, vsync_d, hsync_q, hsync_d, fs_q, fs_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic              start_frame;
    logic [11:0]       h_in, v_in, bw_in;
    logic [15:0]       rgb;

    function automatic logic [11:0] clamp_size(input logic [11:0] v, input logic [11:0] lim);
        if (v == 12'd0) return 12'd1;
        if (v > lim) return lim;
        return v;
    endfunction

    function automatic logic [15:0] bar_rgb(input logic [2:0] b);
        case (b)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    assign h_in  = clamp_size(h_active, MAX_H_L);
    assign v_in  = clamp_size(v_active, MAX_V_L);
    assign bw_in = (h_in[11:3] == 9'd0) ? 12'd1 : {3'b000, h_in[11:3]};

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        ph_d        = ph_q;
        ctr_d       = ctr_q;
        bar_d       = bar_q;
        bar_pix_d   = bar_pix_q;
        mode_d      = mode_q;
        h_eff_d     = h_eff_q;
        v_eff_d     = v_eff_q;
        bw_d        = bw_q;
        vsync_d     = vsync_q;
        hsync_d     = 1'b0;
        fs_d        = 1'b0;
        fcnt_d      = fcnt_q;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                vsync_d = 1'b1;
                if (en) start_frame = 1'b1;
            end
            VS: begin
                vsync_d = 1'b1;
                if (cnt_q == VS_LAST) begin
                    state_d = HBL;
                    cnt_d   = '0;
                    vsync_d = 1'b0;
                    fs_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HBL: begin
                vsync_d = 1'b0;
                if (cnt_q == HB_LAST) begin
                    state_d   = ACT;
                    cnt_d     = '0;
                    hsync_d   = 1'b1;
                    x_d       = 12'd0;
                    ph_d      = 1'b0;
                    bar_d     = 3'd0;
                    bar_pix_d = 12'd0;
                    ctr_d     = ctr_q + DATA_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                vsync_d = 1'b0;
                if (ph_q == PH_LAST && x_q == h_eff_q - 12'd1) begin
                    if (y_q == v_eff_q - 12'd1) begin
                        fcnt_d  = fcnt_q + 16'd1;
                        vsync_d = 1'b1;
                        if (en) start_frame = 1'b1;
                        else    state_d     = IDLE;
                    end else begin
                        state_d = HBL;
                        cnt_d   = '0;
                        x_d     = 12'd0;
                        y_d     = y_q + 12'd1;
                    end
                end else begin
                    hsync_d = 1'b1;
                    ctr_d   = ctr_q + DATA_W'(1);
                    if (ph_q == PH_LAST) begin
                        ph_d = 1'b0;
                        x_d  = x_q + 12'd1;
                        // Bar index saturates so the last bar absorbs the h_eff remainder.
                        if (bar_pix_q == bw_q - 12'd1) begin
                            bar_pix_d = 12'd0;
                            if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
                        end else begin
                            bar_pix_d = bar_pix_q + 12'd1;
                        end
                    end else begin
                        ph_d = 1'b1;
                    end
                end
            end
        endcase

        if (start_frame) begin
            state_d   = VS;
            cnt_d     = '0;
            x_d       = 12'd0;
            y_d       = 12'd0;
            ph_d      = 1'b0;
            ctr_d     = '0;
            bar_d     = 3'd0;
            bar_pix_d = 12'd0;
            mode_d    = mode;
            h_eff_d   = h_in;
            v_eff_d   = v_in;
            bw_d      = bw_in;
            vsync_d   = 1'b1;
        end
    end

    always_comb begin
        data_d = '0;
        rgb    = bar_rgb(bar_d);
        if (hsync_d) begin
            case (mode_q)
                2'd0: data_d = ctr_d;
                2'd1: begin
                    if (BYTES_PER_PIX == 2) data_d = DATA_W'(ph_d ? rgb[7:0] : rgb[15:8]);
                    else                    data_d = DATA_W'(bar_d) << (DATA_W - 3);
                end
                2'd2: data_d = DATA_W'(y_d);
                default: data_d = (x_d[3] ^ y_d[3]) ? '1 : '0;
            endcase
        end
    end

    always_ff @(posedge CCD_PCLK or negedge CCD_RSTN) begin
        if (!CCD_RSTN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_q       <= 12'd0;
            y_q       <= 12'd0;
            ph_q      <= 1'b0;
            ctr_q     <= '0;
            bar_q     <= 3'd0;
            bar_pix_q <= 12'd0;
            mode_q    <= 2'd0;
            h_eff_q   <= 12'd1;
            v_eff_q   <= 12'd1;
            bw_q      <= 12'd1;
            vsync_q   <= 1'b1;
            hsync_q   <= 1'b0;
            data_q    <= '0;
            fs_q      <= 1'b0;
            fcnt_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ph_q      <= ph_d;
            ctr_q     <= ctr_d;
            bar_q     <= bar_d;
            bar_pix_q <= bar_pix_d;
            mode_q    <= mode_d;
            h_eff_q   <= h_eff_d;
            v_eff_q   <= v_eff_d;
            bw_q      <= bw_d;
            vsync_q   <= vsync_d;
            hsync_q   <= hsync_d;
            data_q    <= data_d;
            fs_q      <= fs_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign dvp.CCD_VSYNC = vsync_q;
    assign dvp.CCD_HSYNC = hsync_q;
    assign dvp.CCD_DATA  = data_q;
    assign frame_start   = fs_q;
    assign frame_cnt     = fcnt_q;

endmodule

// File: doc/dvp_pattern_gen.md
# dvp_pattern_gen

Synthesizable DVP camera-source generator with configurable frame size, blanking, bytes per pixel and test pattern. It drives CCD_VSYNC/CCD_HSYNC/CCD_DATA with the same polarity and line structure as the OV5640 capture path expects: VSYNC high between frames, HSYNC high during active bytes. It replaces the sensor in on-board loopback tests and in simulation of the capture/DDR pipeline.

## Interface
Parameters:
- DATA_W, 8, width of CCD_DATA.
- MAX_H, 2048, maximum active pixels per line; runtime h_active is clamped to this.
- MAX_V, 2048, maximum active lines per frame; runtime v_active is clamped to this.
- VS_CYCLES, 10000, CCD_PCLK cycles VSYNC stays high per frame (≥1).
- H_BLANK, 100, cycles with HSYNC low before each line (≥1).
- BYTES_PER_PIX, 1, bytes per pixel (1 or 2). A value of 2 requires DATA_W=8 (RGB565, high byte first).

Ports:
- CCD_PCLK  in  1  pixel clock; all state changes on posedge.
- CCD_RSTN  in  1  asynchronous active-low reset.
- en  in  1  level enable. Sampled only at frame boundaries.
- mode  in  2  pattern select. Latched at frame start.
- h_active  in  12  active pixels per line. Latched at frame start.
- v_active  in  12  active lines per frame. Latched at frame start.
- CCD_VSYNC  out  1  frame sync; high = vertical blanking.
- CCD_HSYNC  out  1  line valid; high = CCD_DATA valid.
- CCD_DATA  out  DATA_W  pixel byte.
- frame_start  out  1  one-cycle pulse on the cycle VSYNC falls.
- frame_cnt  out  16  completed frames, wraps at 2^16.

## Operation
- States:
  - IDLE → VS when en=1.
  - VS: VSYNC=1 for VS_CYCLES cycles, then → HBL.
  - HBL: HSYNC=0 for H_BLANK cycles, then → ACT.
  - ACT: HSYNC=1 for h_eff*BYTES_PER_PIX cycles.
- End of line in ACT:
  - If line < v_eff-1 → HBL.
  - Else end of frame: frame_cnt+1, then → VS if en=1, else → IDLE.
- Sizes and mode are latched on every entry to VS.
  - h_eff = clamp(h_active, 1, MAX_H); v_eff = clamp(v_active, 1, MAX_V). A value of 0 is treated as 1.
- Counters: x (pixel within line), y (line), byte phase, byte counter. x and y reset at VS entry; x also resets at each HBL entry.
- Patterns:
  - mode 0, counter: the first active byte of the frame is 1. The value increments every active byte, wraps mod 2^DATA_W, and continues across lines. It restarts at every frame.
  - mode 1, colour bars: bar width bw = h_eff>>3, minimum 1. The bar index increments each bw pixels and saturates at 7, so the last bar absorbs the remainder.
    - BYTES_PER_PIX=1: data = bar<<(DATA_W-3).
    - BYTES_PER_PIX=2: RGB565 white, yellow, cyan, green, magenta, red, blue, black, i.e. 16'hFFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - mode 2, vertical gradient: every byte of line y = y[DATA_W-1:0].
  - mode 3, checker: all-ones when x[3]^y[3], else 0. Both bytes of a pixel are identical.
- CCD_DATA = 0 whenever HSYNC=0.
- en deasserted mid-frame: the current frame completes fully, then → IDLE. Asserting en in IDLE starts a new frame; no partial frames are ever produced.
- mode/size changes mid-frame have no effect until the next VS entry.

## Timing
- Reset (async, immediate, including mid-frame):
  - state IDLE; CCD_VSYNC=1; CCD_HSYNC=0; CCD_DATA=0.
  - frame_start=0; frame_cnt=0; all counters 0.
- All outputs are registered with no combinational paths from inputs.
- en high sampled at edge k in IDLE: VS is entered at k. VSYNC falls at edge k+VS_CYCLES, and frame_start is high for that one cycle.
- HSYNC rises H_BLANK edges after VSYNC falls, or after the previous HSYNC fall. The first data byte is valid on the same edge HSYNC rises.
- Line period is H_BLANK + h_eff*BYTES_PER_PIX.
- Frame period is VS_CYCLES + v_eff*(H_BLANK + h_eff*BYTES_PER_PIX).
- The last HSYNC fall and the VSYNC rise occur on the same edge, with no gap. frame_cnt updates on that edge.
- With en held high, frames are back-to-back with no IDLE cycle.

## Test plan
- Defaults, mode 0, h/v = 640/480, en=1:
  - VSYNC high 10000 cycles.
  - 480 lines, each 100 low + 640 high HSYNC cycles.
  - Data runs 1..255,0,1,… continuously across lines.
  - frame_cnt=1 at the VSYNC rise.
  - Frame period 365200 cycles.
- BYTES_PER_PIX=2, mode 1, h/v = 16/2:
  - Each line is 32 bytes: FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00, each pixel repeated at bw=2.
- mode 3 and mode 2, h/v = 32/20:
  - mode 3: pixel x=8,y=0 = FF; x=8,y=8 = 00.
  - mode 2: line 19 bytes all = 19.
- Boundaries:
  - h_active=0, v_active=0 → one line of one byte per frame.
  - h_active=4095 with MAX_H=2048 → 2048 active bytes.
- Control:
  - en dropped mid-line 3 of 5 → frame finishes all 5 lines, then IDLE with VSYNC=1 and frame_cnt incremented once.
  - mode change mid-frame takes effect only on the next frame.
- Reset:
  - CCD_RSTN pulsed low mid-ACT → outputs go to reset values within the same cycle with no clock edge needed; frame_cnt=0.
  - After release with en=1, VSYNC falls exactly VS_CYCLES edges after the first sampled edge.
